// File: rtl/reg_timeout_guard.sv
// reg_timeout_guard: sits between one reg_demux port and its register-interface
// peripheral. A request stalled for TimeoutCycles cycles is answered upstream
// with an error response (rdata = ErrData). The peripheral keeps seeing the
// captured request until it finally responds. That late response is discarded.
// Optional feature: define REG_TIMEOUT_GUARD_STATUS_EN to enable the saturating
// timeout_cnt_o counter. Without it, timeout_cnt_o is tied to zero.

package core_v_mcu_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module reg_timeout_guard #(
  parameter int unsigned TimeoutCycles = 1024,
  parameter logic [31:0] ErrData       = 32'hBADC_AB1E,
  parameter type         reg_req_t     = core_v_mcu_pkg::reg_req_t,
  parameter type         reg_rsp_t     = core_v_mcu_pkg::reg_rsp_t
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  reg_req_t     slv_req_i,
  output reg_rsp_t     slv_rsp_o,
  output reg_req_t     mst_req_o,
  input  reg_rsp_t     mst_rsp_i,
  output logic         timeout_o,
  output logic [15:0]  timeout_cnt_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  reg_req_t        hold_q, hold_d;
  logic            timeout;

  // State, stall counter and captured-request register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  // Next state and request/response steering
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    mst_req_o = slv_req_i;
    slv_rsp_o = mst_rsp_i;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if (slv_req_i.valid && !mst_rsp_i.ready) begin
          state_d = WAIT;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // A real response (or upstream abandoning the request) always wins
        // over the timeout, even in the cycle the limit is reached.
        if (!slv_req_i.valid || mst_rsp_i.ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(TimeoutCycles)) begin
          timeout         = 1'b1;
          slv_rsp_o       = '0;
          slv_rsp_o.ready = 1'b1;
          slv_rsp_o.error = 1'b1;
          slv_rsp_o.rdata = ErrData;
          hold_d          = slv_req_i;
          state_d         = DRAIN;
          cnt_d           = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        // Peripheral keeps seeing the captured request; upstream is isolated
        // and every new request is rejected immediately.
        mst_req_o       = hold_q;
        mst_req_o.valid = 1'b1;
        slv_rsp_o       = '0;
        if (slv_req_i.valid) begin
          slv_rsp_o.ready = 1'b1;
          slv_rsp_o.error = 1'b1;
          slv_rsp_o.rdata = ErrData;
        end
        if (mst_rsp_i.ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign timeout_o = timeout;

`ifdef REG_TIMEOUT_GUARD_STATUS_EN
  logic [15:0] tcnt_q;

  // Saturating count of issued timeouts
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tcnt_q <= '0;
    end else if (timeout && (tcnt_q != '1)) begin
      tcnt_q <= tcnt_q + 16'd1;
    end
  end

  assign timeout_cnt_o = tcnt_q;
`else
  assign timeout_cnt_o = '0;
`endif

endmodule

// File: tb/tb_reg_timeout_guard.sv
// Directed bench for reg_timeout_guard with TimeoutCycles = 8.
// Each step drives inputs just after a rising edge and pushes the expected
// outputs to a scoreboard queue. The outputs are popped and compared at the
// following falling edge.
module tb_reg_timeout_guard;

  localparam logic [31:0] ERR = 32'hBADC_AB1E;
`ifdef REG_TIMEOUT_GUARD_STATUS_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic        rrdy;
    logic        rerr;
    logic [31:0] rdata;
    logic        mvalid;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        tmo;
    logic [15:0] tcnt;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  core_v_mcu_pkg::reg_req_t slv_req;
  core_v_mcu_pkg::reg_rsp_t slv_rsp;
  core_v_mcu_pkg::reg_req_t mst_req;
  core_v_mcu_pkg::reg_rsp_t mst_rsp;
  logic                     timeout;
  logic [15:0]              timeout_cnt;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] tc_exp  = '0;

  reg_timeout_guard #(
    .TimeoutCycles(8),
    .ErrData      (ERR)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .slv_req_i    (slv_req),
    .slv_rsp_o    (slv_rsp),
    .mst_req_o    (mst_req),
    .mst_rsp_i    (mst_rsp),
    .timeout_o    (timeout),
    .timeout_cnt_o(timeout_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag,
                      input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic mr, input logic [31:0] md,
                      input logic er, input logic ee, input logic [31:0] ed,
                      input logic emv, input logic [31:0] ema, input logic [31:0] emd,
                      input logic etmo);
    exp_t e;
    slv_req.valid = sv;
    slv_req.addr  = sa;
    slv_req.wdata = sd;
    slv_req.write = (sd != 32'd0);
    slv_req.wstrb = (sd != 32'd0) ? 4'hF : 4'h0;
    mst_rsp.ready = mr;
    mst_rsp.rdata = md;
    mst_rsp.error = 1'b0;
    sb.push_back('{tag, er, ee, ed, emv, ema, emd, etmo, tc_exp});
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, ".rsp_ready"}, 32'(slv_rsp.ready), 32'(e.rrdy));
    check({e.tag, ".rsp_error"}, 32'(slv_rsp.error), 32'(e.rerr));
    check({e.tag, ".rsp_rdata"}, slv_rsp.rdata, e.rdata);
    check({e.tag, ".mst_valid"}, 32'(mst_req.valid), 32'(e.mvalid));
    check({e.tag, ".mst_addr"}, mst_req.addr, e.maddr);
    check({e.tag, ".mst_wdata"}, mst_req.wdata, e.mwdata);
    check({e.tag, ".timeout"}, 32'(timeout), 32'(e.tmo));
    check({e.tag, ".timeout_cnt"}, 32'(timeout_cnt), 32'(e.tcnt));
    @(posedge clk);
    #1;
    if (rst) tc_exp = '0;
    else if (etmo && STAT && tc_exp != 16'hFFFF) tc_exp = tc_exp + 16'd1;
  endtask

  // Transparent cycle: response from peripheral, request to peripheral
  task automatic pass(input string tag, input logic sv, input logic [31:0] sa,
                      input logic [31:0] sd, input logic mr, input logic [31:0] md);
    step(tag, sv, sa, sd, mr, md, mr, 1'b0, md, sv, sa, sd, 1'b0);
  endtask

  initial begin
    rst     = 1'b1;
    slv_req = '0;
    mst_rsp = '0;
    @(posedge clk);
    #1;
    pass("rst", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;

    // Same-cycle ready read
    pass("rd_same", 1'b1, 32'h10, 32'h0, 1'b1, 32'h1234_5678);

    // Five stalled cycles then real response, then IDLE passthrough
    for (int i = 0; i < 5; i++) pass("stall5", 1'b1, 32'h14, 32'h0, 1'b0, 32'h0);
    pass("stall5_rsp", 1'b1, 32'h14, 32'h0, 1'b1, 32'hCAFE_0001);
    pass("stall5_idle", 1'b1, 32'h18, 32'h0, 1'b1, 32'h0000_00AA);

    // Peripheral never ready: timeout when counter reaches 8
    for (int i = 0; i < 8; i++) pass("to_wait", 1'b1, 32'h20, 32'hAAAA_5555, 1'b0, 32'h0);
    step("to_err", 1'b1, 32'h20, 32'hAAAA_5555, 1'b0, 32'h0,
         1'b1, 1'b1, ERR, 1'b1, 32'h20, 32'hAAAA_5555, 1'b1);

    // DRAIN: new write rejected, captured request held until peripheral ready
    step("drain_wr", 1'b1, 32'h30, 32'h1111_2222, 1'b0, 32'h0,
         1'b1, 1'b1, ERR, 1'b1, 32'h20, 32'hAAAA_5555, 1'b0);
    step("drain_idle", 1'b0, 32'h34, 32'h0, 1'b0, 32'h0,
         1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 32'hAAAA_5555, 1'b0);
    step("drain_rdy", 1'b0, 32'h34, 32'h0, 1'b1, 32'h0000_DEAD,
         1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 32'hAAAA_5555, 1'b0);
    pass("post_drain", 1'b1, 32'h40, 32'h0, 1'b1, 32'h0000_5A5A);

    // Ready arrives in the counter==8 cycle: real response wins
    for (int i = 0; i < 8; i++) pass("edge_wait", 1'b1, 32'h50, 32'h0, 1'b0, 32'h0);
    pass("edge_rdy", 1'b1, 32'h50, 32'h0, 1'b1, 32'h0000_0077);
    pass("edge_idle", 1'b1, 32'h54, 32'h0, 1'b1, 32'h0000_0099);

    // Upstream drops valid mid-WAIT: counter restarts from scratch
    for (int i = 0; i < 4; i++) pass("viol_wait", 1'b1, 32'h60, 32'h0, 1'b0, 32'h0);
    pass("viol_drop", 1'b0, 32'h60, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) pass("viol_rewait", 1'b1, 32'h64, 32'h0BAD_F00D, 1'b0, 32'h0);
    step("viol_err", 1'b1, 32'h64, 32'h0BAD_F00D, 1'b0, 32'h0,
         1'b1, 1'b1, ERR, 1'b1, 32'h64, 32'h0BAD_F00D, 1'b1);

    // Reset while in DRAIN
    rst = 1'b1;
    step("rst_drain", 1'b0, 32'h70, 32'h0, 1'b0, 32'h0,
         1'b0, 1'b0, 32'h0, 1'b1, 32'h64, 32'h0BAD_F00D, 1'b0);
    rst = 1'b0;
    pass("rst_idle", 1'b0, 32'h70, 32'h0, 1'b0, 32'h0);
    pass("rst_pass", 1'b1, 32'h74, 32'h0, 1'b1, 32'h0000_1111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
